reorder_buffer: RTL and testbench

//  Circular reorder buffer for the Tomasulo core. Allocates one tag per issued instruction and captures RS/LSB results.

---
 rtl/reorder_buffer_pkg.sv | 40 ++++
 rtl/rob_query_port.sv | 45 ++++
 rtl/reorder_buffer.sv | 175 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types, constants and tag arithmetic for the reorder buffer.
// Tag 0 is reserved as the null tag; live tags run 1..ROB_CAP and wrap.
package reorder_buffer_pkg;

  localparam int ENTRY_SIZE = 4;
  localparam int ROB_DEPTH  = 1 << ENTRY_SIZE;
  localparam int ROB_CAP    = ROB_DEPTH - 1;

  typedef logic [ENTRY_SIZE-1:0] tag_t;
  typedef logic [ENTRY_SIZE:0]   count_t;
  typedef logic [5:0]            reg_idx_t;
  typedef logic [31:0]           word_t;

  localparam tag_t     ENTRY_NULL = '0;
  localparam tag_t     TAG_FIRST  = tag_t'(1);
  localparam tag_t     TAG_LAST   = tag_t'(ROB_CAP);
  localparam count_t   COUNT_CAP  = count_t'(ROB_CAP);
  localparam count_t   COUNT_FULL = count_t'(ROB_CAP - 1);
  localparam reg_idx_t REG_NULL   = '0;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    rob_type_e kind;
    reg_idx_t  rd;
    word_t     pc;
    logic      pred;
    logic      jump;
    word_t     target;
  } rob_meta_t;

  function automatic tag_t next_tag(input tag_t t);
    return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand lookup for dispatch: returns a resolved tag's value.
// ROB_FWD_EN: also forwards the current cycle's rs/lsb broadcast (rs first).
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  tag_t                 query_entry,
  input  logic [ROB_DEPTH-1:0] valid,
  input  logic [ROB_DEPTH-1:0] ready,
  input  word_t                result [ROB_DEPTH],
  input  logic                 rs_broadcast,
  input  tag_t                 rs_entry,
  input  word_t                rs_result,
  input  logic                 lsb_broadcast,
  input  tag_t                 lsb_entry,
  input  word_t                lsb_result,
  output logic                 query_ready,
  output word_t                query_value
);

`ifdef ROB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic live;
  assign live = (query_entry != ENTRY_NULL) && valid[query_entry];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    query_ready = 1'b0;
    query_value = '0;
    if (live && ready[query_entry]) begin
      query_ready = 1'b1;
      query_value = result[query_entry];
    end else if (FWD && live && rs_broadcast && rs_entry == query_entry) begin
      query_ready = 1'b1;
      query_value = rs_result;
    end else if (FWD && live && lsb_broadcast && lsb_entry == query_entry) begin
      query_ready = 1'b1;
      query_value = lsb_result;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement, store release and mispredict flush.
// Optional ROB_FWD_EN makes operand queries see same-cycle broadcasts.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       issue_valid,
  input  logic [1:0] issue_type,
  input  reg_idx_t   issue_rd,
  input  word_t      issue_pc,
  input  logic       issue_pred_jump,
  output tag_t       rob_new_entry,
  output logic       rob_full,
  input  logic       rs_broadcast,
  input  tag_t       rs_entry,
  input  word_t      rs_result,
  input  logic       rs_jump,
  input  word_t      rs_target,
  input  logic       lsb_broadcast,
  input  tag_t       lsb_entry,
  input  word_t      lsb_result,
  input  tag_t       query_j_entry,
  input  tag_t       query_k_entry,
  output logic       query_j_ready,
  output word_t      query_j_value,
  output logic       query_k_ready,
  output word_t      query_k_value,
  output logic       rob_commit,
  output tag_t       rob_entry,
  output reg_idx_t   rob_des,
  output word_t      rob_result,
  output logic       store_commit,
  output tag_t       store_entry,
  output logic       roll_back,
  output word_t      rollback_pc
);

  logic [ROB_DEPTH-1:0] valid;
  logic [ROB_DEPTH-1:0] ready;
  rob_meta_t            meta       [ROB_DEPTH];
  word_t                result_mem [ROB_DEPTH];
  tag_t                 head;
  tag_t                 tail;
  count_t               count;

  rob_meta_t head_meta;
  logic      issue_ok;
  logic      rs_hit;
  logic      lsb_hit;
  logic      commit_ok;
  logic      mispredict;

  // The cycle roll_back is high belongs to the wrong path: nothing is accepted.
  assign issue_ok   = issue_valid && (count != COUNT_CAP) && !roll_back;
  assign rs_hit     = rs_broadcast && (rs_entry != ENTRY_NULL) && valid[rs_entry] && !roll_back;
  assign lsb_hit    = lsb_broadcast && (lsb_entry != ENTRY_NULL) && valid[lsb_entry]
                      && !(rs_broadcast && rs_entry == lsb_entry) && !roll_back;
  assign head_meta  = meta[head];
  assign commit_ok  = valid[head] && ready[head] && !roll_back;
  assign mispredict = (head_meta.kind == ROB_BRANCH) && (head_meta.jump != head_meta.pred);

  assign rob_new_entry = tail;
  assign rob_full      = (count >= COUNT_FULL);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every read sees the pre-edge value.
    if (rst_in) begin
      valid        <= '0;
      ready        <= '0;
      head         <= TAG_FIRST;
      tail         <= TAG_FIRST;
      count        <= '0;
      rob_commit   <= 1'b0;
      rob_entry    <= ENTRY_NULL;
      rob_des      <= REG_NULL;
      rob_result   <= '0;
      store_commit <= 1'b0;
      store_entry  <= ENTRY_NULL;
      roll_back    <= 1'b0;
      rollback_pc  <= '0;
    end else if (!rdy_in) begin
      rob_commit   <= 1'b0;
      store_commit <= 1'b0;
      roll_back    <= 1'b0;
    end else begin
      rob_commit   <= commit_ok;
      store_commit <= commit_ok && (head_meta.kind == ROB_STORE);
      roll_back    <= commit_ok && mispredict;
      if (commit_ok) begin
        rob_entry  <= head;
        rob_des    <= (head_meta.kind == ROB_STORE) ? REG_NULL : head_meta.rd;
        rob_result <= result_mem[head];
        if (head_meta.kind == ROB_STORE) store_entry <= head;
        if (mispredict) rollback_pc <= head_meta.jump ? head_meta.target : head_meta.pc + 32'd4;
      end

      if (commit_ok && mispredict) begin
        valid <= '0;
        ready <= '0;
        head  <= TAG_FIRST;
        tail  <= TAG_FIRST;
        count <= '0;
      end else begin
        if (issue_ok) begin
          valid[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= next_tag(tail);
        end
        if (rs_hit)  ready[rs_entry]  <= 1'b1;
        if (lsb_hit) ready[lsb_entry] <= 1'b1;
        if (commit_ok) begin
          valid[head] <= 1'b0;
          head        <= next_tag(head);
        end
        unique case ({issue_ok, commit_ok})
          2'b10:   count <= count + count_t'(1);
          2'b01:   count <= count - count_t'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: payload storage is not reset; valid/ready gate every read of it.
  always_ff @(posedge clk) begin
    if (!rst_in && rdy_in) begin
      if (issue_ok) begin
        meta[tail] <= '{kind: rob_type_e'(issue_type), rd: issue_rd, pc: issue_pc,
                        pred: issue_pred_jump, jump: 1'b0, target: '0};
      end
      if (rs_hit) begin
        result_mem[rs_entry]  <= rs_result;
        meta[rs_entry].jump   <= rs_jump;
        meta[rs_entry].target <= rs_target;
      end
      if (lsb_hit) result_mem[lsb_entry] <= lsb_result;
    end
  end

  issue_when_full: assert property (@(posedge clk) disable iff (rst_in)
    !(rdy_in && issue_valid && !roll_back && count == COUNT_CAP));

  rob_query_port u_query_j (
    .query_entry  (query_j_entry),
    .valid        (valid),
    .ready        (ready),
    .result       (result_mem),
    .rs_broadcast (rs_broadcast),
    .rs_entry     (rs_entry),
    .rs_result    (rs_result),
    .lsb_broadcast(lsb_broadcast),
    .lsb_entry    (lsb_entry),
    .lsb_result   (lsb_result),
    .query_ready  (query_j_ready),
    .query_value  (query_j_value)
  );

  rob_query_port u_query_k (
    .query_entry  (query_k_entry),
    .valid        (valid),
    .ready        (ready),
    .result       (result_mem),
    .rs_broadcast (rs_broadcast),
    .rs_entry     (rs_entry),
    .rs_result    (rs_result),
    .lsb_broadcast(lsb_broadcast),
    .lsb_entry    (lsb_entry),
    .lsb_result   (lsb_result),
    .query_ready  (query_k_ready),
    .query_value  (query_k_value)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus a randomized phase, all
// compared every cycle against a queue-based program-order model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_pred_jump;
  logic [1:0]  issue_type;
  logic [5:0]  issue_rd;
  logic [31:0] issue_pc;
  logic [3:0]  rob_new_entry;
  logic        rob_full;
  logic        rs_broadcast, rs_jump;
  logic [3:0]  rs_entry;
  logic [31:0] rs_result, rs_target;
  logic        lsb_broadcast;
  logic [3:0]  lsb_entry;
  logic [31:0] lsb_result;
  logic [3:0]  query_j_entry, query_k_entry;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        rob_commit, store_commit, roll_back;
  logic [3:0]  rob_entry, store_entry;
  logic [5:0]  rob_des;
  logic [31:0] rob_result, rollback_pc;

  reorder_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .rob_new_entry(rob_new_entry), .rob_full(rob_full),
    .rs_broadcast(rs_broadcast), .rs_entry(rs_entry), .rs_result(rs_result),
    .rs_jump(rs_jump), .rs_target(rs_target),
    .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
    .query_j_entry(query_j_entry), .query_k_entry(query_k_entry),
    .query_j_ready(query_j_ready), .query_j_value(query_j_value),
    .query_k_ready(query_k_ready), .query_k_value(query_k_value),
    .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_des(rob_des),
    .rob_result(rob_result), .store_commit(store_commit), .store_entry(store_entry),
    .roll_back(roll_back), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  kind;
    logic [5:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        ready;
    logic [31:0] result;
    logic        jump;
    logic [31:0] target;
  } m_entry_t;

  m_entry_t    m_q[$];
  logic [3:0]  m_next = 4'd1;
  logic        exp_commit = 1'b0, exp_store = 1'b0, exp_roll = 1'b0;
  logic [3:0]  exp_entry, exp_store_entry;
  logic [5:0]  exp_des;
  logic [31:0] exp_result, exp_rpc;
  logic [3:0]  commit_log[$];

  function automatic int find(input logic [3:0] tag);
    foreach (m_q[i]) if (m_q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic model_step();
    m_entry_t e;
    logic     was_roll;
    int       size0, idx;
    if (rst_in) begin
      m_q.delete(); m_next = 4'd1;
      exp_commit = 0; exp_store = 0; exp_roll = 0;
      return;
    end
    if (!rdy_in) begin
      exp_commit = 0; exp_store = 0; exp_roll = 0;
      return;
    end
    was_roll = exp_roll;
    size0 = m_q.size();
    exp_commit = 0; exp_store = 0; exp_roll = 0;
    if (!was_roll && size0 > 0 && m_q[0].ready) begin
      e = m_q[0];
      m_q.delete(0);
      exp_commit = 1; exp_entry = e.tag; exp_result = e.result;
      exp_des = (e.kind == K_STORE) ? 6'd0 : e.rd;
      if (e.kind == K_STORE) begin exp_store = 1; exp_store_entry = e.tag; end
      if (e.kind == K_BRANCH && e.jump != e.pred) begin
        exp_roll = 1;
        exp_rpc  = e.jump ? e.target : e.pc + 32'd4;
        m_q.delete(); m_next = 4'd1;
        return;
      end
    end
    if (was_roll) return;
    if (rs_broadcast && rs_entry != 4'd0) begin
      idx = find(rs_entry);
      if (idx >= 0) begin
        m_q[idx].ready = 1; m_q[idx].result = rs_result;
        m_q[idx].jump = rs_jump; m_q[idx].target = rs_target;
      end
    end
    if (lsb_broadcast && lsb_entry != 4'd0 && !(rs_broadcast && rs_entry == lsb_entry)) begin
      idx = find(lsb_entry);
      if (idx >= 0) begin m_q[idx].ready = 1; m_q[idx].result = lsb_result; end
    end
    if (issue_valid && size0 < 15) begin
      e = '{tag: m_next, kind: issue_type, rd: issue_rd, pc: issue_pc, pred: issue_pred_jump,
            ready: 1'b0, result: 32'd0, jump: 1'b0, target: 32'd0};
      m_q.push_back(e);
      m_next = (m_next == 4'd15) ? 4'd1 : m_next + 4'd1;
    end
  endtask

  task automatic exp_query(input logic [3:0] tag, output logic r, output logic [31:0] v);
    int idx;
    r = 0; v = 0;
    if (tag == 4'd0) return;
    idx = find(tag);
    if (idx < 0) return;
    if (m_q[idx].ready) begin r = 1; v = m_q[idx].result; end
`ifdef ROB_FWD_EN
    else if (rs_broadcast && rs_entry == tag) begin r = 1; v = rs_result; end
    else if (lsb_broadcast && lsb_entry == tag) begin r = 1; v = lsb_result; end
`endif
  endtask

  task automatic check_queries();
    logic r; logic [31:0] v;
    exp_query(query_j_entry, r, v);
    check("query_j_ready", 64'(query_j_ready), 64'(r));
    check("query_j_value", 64'(query_j_value), 64'(v));
    exp_query(query_k_entry, r, v);
    check("query_k_ready", 64'(query_k_ready), 64'(r));
    check("query_k_value", 64'(query_k_value), 64'(v));
  endtask

  task automatic check_regs();
    check("rob_commit", 64'(rob_commit), 64'(exp_commit));
    if (exp_commit) begin
      check("rob_entry",  64'(rob_entry),  64'(exp_entry));
      check("rob_des",    64'(rob_des),    64'(exp_des));
      check("rob_result", 64'(rob_result), 64'(exp_result));
    end
    check("store_commit", 64'(store_commit), 64'(exp_store));
    if (exp_store) check("store_entry", 64'(store_entry), 64'(exp_store_entry));
    check("roll_back", 64'(roll_back), 64'(exp_roll));
    if (exp_roll) check("rollback_pc", 64'(rollback_pc), 64'(exp_rpc));
    check("rob_new_entry", 64'(rob_new_entry), 64'(m_next));
    check("rob_full", 64'(rob_full), 64'(m_q.size() >= 14));
    if (rob_commit === 1'b1) commit_log.push_back(rob_entry);
  endtask

  // One clock: query check before the edge, model update at the edge, outputs after.
  task automatic step();
    #1;
    check_queries();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
    issue_valid = 0; rs_broadcast = 0; lsb_broadcast = 0;
  endtask

  task automatic set_issue(input logic [1:0] kind, input logic [5:0] rd,
                           input logic [31:0] pc, input logic pred);
    issue_valid = 1; issue_type = kind; issue_rd = rd; issue_pc = pc; issue_pred_jump = pred;
  endtask

  task automatic set_rs(input logic [3:0] tag, input logic [31:0] res,
                        input logic jump, input logic [31:0] target);
    rs_broadcast = 1; rs_entry = tag; rs_result = res; rs_jump = jump; rs_target = target;
  endtask

  task automatic set_lsb(input logic [3:0] tag, input logic [31:0] res);
    lsb_broadcast = 1; lsb_entry = tag; lsb_result = res;
  endtask

  task automatic do_reset();
    rst_in = 1; step(); rst_in = 0;
  endtask

  task automatic complete(input int idx);
    if (m_q[idx].kind == K_STORE) set_lsb(m_q[idx].tag, $urandom);
    else set_rs(m_q[idx].tag, $urandom, m_q[idx].pred, $urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && m_q.size() > 0; n++) begin
      int c = -1;
      foreach (m_q[i]) if (!m_q[i].ready && c < 0) c = i;
      if (c >= 0) complete(c);
      step();
    end
  endtask

  initial begin
    rst_in = 1; rdy_in = 1;
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0; issue_pred_jump = 0;
    rs_broadcast = 0; rs_entry = 0; rs_result = 0; rs_jump = 0; rs_target = 0;
    lsb_broadcast = 0; lsb_entry = 0; lsb_result = 0;
    query_j_entry = 0; query_k_entry = 0;
    @(negedge clk);

    // Reset state and a single REG instruction end to end.
    do_reset();
    check("reset_new_entry", 64'(rob_new_entry), 64'd1);
    check("reset_commit", 64'(rob_commit), 64'd0);
    set_issue(K_REG, 6'd5, 32'h0, 1'b0); step();
    set_rs(4'd1, 32'h1234, 1'b0, 32'h0); step();
    step();
    check("t1_commit", 64'(rob_commit), 64'd1);
    check("t1_entry", 64'(rob_entry), 64'd1);
    check("t1_des", 64'(rob_des), 64'd5);
    check("t1_result", 64'(rob_result), 64'h1234);

    // Fill, full threshold and tag wrap.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      set_issue(K_REG, 6'(i), 32'(i * 4), 1'b0); step();
      if (i == 13) check("full_at_13", 64'(rob_full), 64'd0);
      if (i == 14) check("full_at_14", 64'(rob_full), 64'd1);
    end
    check("wrap_new_entry", 64'(rob_new_entry), 64'd1);
    set_rs(4'd1, 32'h11, 1'b0, 32'h0); step();
    step();
    check("wrap_commit_1", 64'(rob_entry), 64'd1);
    set_issue(K_REG, 6'd20, 32'h400, 1'b0); step();
    check("wrap_reuse_tag1", 64'(rob_new_entry), 64'd2);
    check("wrap_full_again", 64'(rob_full), 64'd1);
    drain();

    // Out-of-order completion retires in program order.
    do_reset();
    for (int i = 1; i <= 3; i++) begin set_issue(K_REG, 6'(i), 32'(i * 4), 1'b0); step(); end
    commit_log.delete();
    set_rs(4'd3, 32'h33, 1'b0, 32'h0); step();
    set_rs(4'd1, 32'h11, 1'b0, 32'h0); step();
    set_rs(4'd2, 32'h22, 1'b0, 32'h0); step();
    for (int i = 0; i < 4; i++) step();
    check("ooo_count", 64'(commit_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < commit_log.size(); i++)
      check("ooo_order", 64'(commit_log[i]), 64'(i + 1));

    // Mispredicted branch at head: flush and redirect.
    do_reset();
    set_issue(K_BRANCH, 6'd0, 32'h100, 1'b0); step();
    set_issue(K_REG, 6'd7, 32'h104, 1'b0); step();
    set_rs(4'd1, 32'h104, 1'b1, 32'h200); step();
    set_lsb(4'd2, 32'h55); step();
    check("rb_pulse", 64'(roll_back), 64'd1);
    check("rb_pc", 64'(rollback_pc), 64'h200);
    query_j_entry = 4'd2;
    set_issue(K_REG, 6'd3, 32'h300, 1'b0);
    set_rs(4'd2, 32'h66, 1'b0, 32'h0); step();
    check("rb_empty_tail", 64'(rob_new_entry), 64'd1);
    check("rb_no_commit", 64'(rob_commit), 64'd0);
    step();
    check("rb_no_commit_2", 64'(rob_commit), 64'd0);
    query_j_entry = 4'd0;

    // Store release and pause.
    do_reset();
    set_issue(K_REG, 6'd4, 32'h500, 1'b0); step();
    set_issue(K_STORE, 6'd9, 32'h504, 1'b0); step();
    set_lsb(4'd2, 32'hDEAD); step();
    set_rs(4'd1, 32'h77, 1'b0, 32'h0); step();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      set_issue(K_REG, 6'd1, 32'h0, 1'b0); step();
      check("pause_no_commit", 64'(rob_commit), 64'd0);
    end
    rdy_in = 1;
    step();
    check("pause_resume_entry", 64'(rob_entry), 64'd1);
    step();
    check("store_commit", 64'(store_commit), 64'd1);
    check("store_entry", 64'(store_entry), 64'd2);
    check("store_des_null", 64'(rob_des), 64'd0);
    check("store_rob_commit", 64'(rob_commit), 64'd1);

    // Same-cycle forwarding on a query.
    do_reset();
    for (int i = 1; i <= 4; i++) begin set_issue(K_REG, 6'(i), 32'(i * 4), 1'b0); step(); end
    query_k_entry = 4'd4;
    set_rs(4'd4, 32'hAB, 1'b0, 32'h0);
    #1;
`ifdef ROB_FWD_EN
    check("fwd_ready", 64'(query_k_ready), 64'd1);
    check("fwd_value", 64'(query_k_value), 64'hAB);
`else
    check("fwd_ready", 64'(query_k_ready), 64'd0);
`endif
    step();
    check("fwd_next_ready", 64'(query_k_ready), 64'd1);
    check("fwd_next_value", 64'(query_k_value), 64'hAB);
    query_k_entry = 4'd0;

    // Randomized traffic without mispredicts.
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int cand[$];
      rdy_in = ($urandom % 8) != 0;
      query_j_entry = 4'($urandom_range(0, 15));
      query_k_entry = 4'($urandom_range(0, 15));
      if (m_q.size() < 15 && ($urandom % 2) == 0)
        set_issue(2'($urandom_range(0, 2)), 6'($urandom_range(0, 31)),
                  {$urandom} & 32'hFFFF_FFFC, 1'($urandom));
      foreach (m_q[i]) if (!m_q[i].ready) cand.push_back(i);
      if (cand.size() > 0 && ($urandom % 3) != 0) begin
        int idx = cand[$urandom_range(0, cand.size() - 1)];
        if (m_q[idx].kind == K_STORE || (m_q[idx].kind == K_REG && ($urandom % 4) == 0))
          set_lsb(m_q[idx].tag, $urandom);
        else
          set_rs(m_q[idx].tag, $urandom, m_q[idx].pred, $urandom);
      end
      if (!rs_broadcast && ($urandom % 6) == 0) begin
        for (int t = 0; t < 16; t++)
          if (find(4'(t)) < 0) begin set_rs(4'(t), $urandom, 1'b0, 32'h0); break; end
      end
      step();
    end
    rdy_in = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
